// File: rtl/prog_loader_pkg.sv
// -----------------------------------------------------------------------------
// prog_loader_pkg
// Shared definitions for the program loader: sequencer state encoding, the
// full-word write strobe, the default run-cycle limit and the mapping from
// sequencer state to the registered control outputs.
// -----------------------------------------------------------------------------
package prog_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_HOLD = 3'd2,
    ST_RUN  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam logic [3:0]  WEN_FULL        = 4'hF;
  localparam int unsigned RUN_TIMEOUT_DEF = 32'd1000000;

  // Control outputs that depend only on the state being entered.
  typedef struct packed {
    logic busy;
    logic done;
    logic s_ready;
    logic core_resetn;
    logic core_clk_en;
  } ctrl_t;

  // The core sees reset asserted everywhere except RUN and DONE; its clock only
  // runs in HOLD (so reset is clocked into it) and RUN.
  function automatic ctrl_t state_ctrl(input state_t st);
    ctrl_t c;
    c = 5'b0;
    case (st)
      ST_LOAD: begin
        c.busy    = 1'b1;
        c.s_ready = 1'b1;
      end
      ST_HOLD: begin
        c.busy        = 1'b1;
        c.core_clk_en = 1'b1;
      end
      ST_RUN: begin
        c.busy        = 1'b1;
        c.core_resetn = 1'b1;
        c.core_clk_en = 1'b1;
      end
      ST_DONE: begin
        c.done        = 1'b1;
        c.core_resetn = 1'b1;
      end
      default: c = 5'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/prog_loader_run_monitor.sv
// -----------------------------------------------------------------------------
// prog_loader_run_monitor
// Counts cycles spent in RUN and decode-trigger pulses, and detects the end of
// a run (trap or cycle limit).
// Ports:
//   clk, resetn       clock, asynchronous active-low reset
//   clear             zero counters and timeout flag (new run being started)
//   en                sequencer is in RUN this cycle (and not aborting)
//   trap, dec_trigger core status inputs
//   run_cycles        cycles counted in RUN
//   trigger_count     dec_trigger pulses in RUN, saturating
//   timeout           last run ended on the cycle limit
//   run_end           combinational: this RUN cycle is the last one
// -----------------------------------------------------------------------------
module prog_loader_run_monitor
  import prog_loader_pkg::*;
#(
  parameter int unsigned RUN_TIMEOUT = RUN_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        clear,
  input  logic        en,
  input  logic        trap,
  input  logic        dec_trigger,
  output logic [31:0] run_cycles,
  output logic [15:0] trigger_count,
  output logic        timeout,
  output logic        run_end
);

  logic limit_s;

  // This cycle brings run_cycles up to the limit.
  assign limit_s = ((run_cycles + 32'd1) == 32'(RUN_TIMEOUT));
  assign run_end = en && (trap || limit_s);

  // Run counters; trap on the limiting cycle wins over the timeout flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      run_cycles    <= 32'd0;
      trigger_count <= 16'd0;
      timeout       <= 1'b0;
    end else if (clear) begin
      run_cycles    <= 32'd0;
      trigger_count <= 16'd0;
      timeout       <= 1'b0;
    end else if (en) begin
      run_cycles <= run_cycles + 32'd1;
      if (dec_trigger && (trigger_count != 16'hFFFF)) begin
        trigger_count <= trigger_count + 16'd1;
      end
      if (limit_s && !trap) begin
        timeout <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
// Host-side sequencer: streams instruction words into code memory from word 0,
// holds the core in reset for RESET_HOLD cycles, then runs it until trap or
// RUN_TIMEOUT cycles, reporting run length and decode-trigger count.
// Ports:
//   clk, resetn                    clock, asynchronous active-low reset
//   start, abort, load_len         control pulses and load length (0 = rerun)
//   s_valid, s_data, s_ready       host word stream
//   inst_mem_en/wen/addr/data      code-memory write port (registered)
//   core_resetn, core_clk_en       core control (registered)
//   trap, dec_trigger              core status
//   busy, done, timeout            sequencer status
//   run_cycles, trigger_count      run statistics
// -----------------------------------------------------------------------------
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int          ADDR_W      = 13,
  parameter int          RESET_HOLD  = 4,
  parameter int unsigned RUN_TIMEOUT = RUN_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W:0]   load_len,
  input  logic              s_valid,
  input  logic [31:0]       s_data,
  output logic              s_ready,
  output logic              inst_mem_en,
  output logic [3:0]        inst_mem_wen,
  output logic [ADDR_W-1:0] inst_mem_addr,
  output logic [31:0]       inst_mem_data,
  output logic              core_resetn,
  output logic              core_clk_en,
  input  logic              trap,
  input  logic              dec_trigger,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [31:0]       run_cycles,
  output logic [15:0]       trigger_count
);

  localparam logic [ADDR_W:0] DEPTH    = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam int              HOLD_W   = $clog2(RESET_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  state_t            state_r;
  state_t            state_nxt_s;
  ctrl_t             ctrl_r;
  logic [ADDR_W:0]   len_r;
  logic [ADDR_W:0]   cnt_r;      // words accepted so far; low bits are the next address
  logic [HOLD_W-1:0] hold_cnt_r;
  logic              accept_s;
  logic              last_word_s;
  logic              start_ok_s;
  logic              run_en_s;
  logic              run_end_s;

  // An abort in the handshake cycle cancels the write.
  assign accept_s    = s_valid && ctrl_r.s_ready && !abort;
  assign last_word_s = (cnt_r == (len_r - LEN_ONE));
  assign start_ok_s  = start && !abort && ((state_r == ST_IDLE) || (state_r == ST_DONE));
  assign run_en_s    = (state_r == ST_RUN) && !abort;

  assign s_ready     = ctrl_r.s_ready;
  assign busy        = ctrl_r.busy;
  assign done        = ctrl_r.done;
  assign core_resetn = ctrl_r.core_resetn;
  assign core_clk_en = ctrl_r.core_clk_en;

  // Next-state selection; abort overrides everything.
  always_comb begin
    state_nxt_s = state_r;
    if (abort) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            if (load_len != {(ADDR_W+1){1'b0}}) begin
              state_nxt_s = ST_LOAD;
            end else begin
              state_nxt_s = ST_HOLD;
            end
          end else begin
            state_nxt_s = state_r;
          end
        end
        ST_LOAD: begin
          if (accept_s && last_word_s) begin
            state_nxt_s = ST_HOLD;
          end else begin
            state_nxt_s = ST_LOAD;
          end
        end
        ST_HOLD: begin
          if (hold_cnt_r == HOLD_LAST) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_HOLD;
          end
        end
        ST_RUN: begin
          if (run_end_s) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // Sequencer state, control outputs and code-memory write port.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r       <= ST_IDLE;
      ctrl_r        <= state_ctrl(ST_IDLE);
      len_r         <= {(ADDR_W+1){1'b0}};
      cnt_r         <= {(ADDR_W+1){1'b0}};
      hold_cnt_r    <= {HOLD_W{1'b0}};
      inst_mem_en   <= 1'b0;
      inst_mem_wen  <= 4'h0;
      inst_mem_addr <= {ADDR_W{1'b0}};
      inst_mem_data <= 32'd0;
    end else begin
      state_r <= state_nxt_s;
      ctrl_r  <= state_ctrl(state_nxt_s);

      if (start_ok_s) begin
        // Lengths beyond the memory depth are clamped so the address never wraps.
        len_r <= (load_len > DEPTH) ? DEPTH : load_len;
        cnt_r <= {(ADDR_W+1){1'b0}};
      end else if (accept_s) begin
        cnt_r <= cnt_r + LEN_ONE;
      end else begin
        cnt_r <= cnt_r;
      end

      if ((state_r == ST_HOLD) && !abort) begin
        hold_cnt_r <= hold_cnt_r + HOLD_ONE;
      end else begin
        hold_cnt_r <= {HOLD_W{1'b0}};
      end

      inst_mem_en  <= accept_s;
      inst_mem_wen <= accept_s ? WEN_FULL : 4'h0;
      if (accept_s) begin
        inst_mem_addr <= cnt_r[ADDR_W-1:0];
        inst_mem_data <= s_data;
      end
    end
  end

  prog_loader_run_monitor #(
    .RUN_TIMEOUT (RUN_TIMEOUT)
  ) u_run_monitor (
    .clk           (clk),
    .resetn        (resetn),
    .clear         (start_ok_s),
    .en            (run_en_s),
    .trap          (trap),
    .dec_trigger   (dec_trigger),
    .run_cycles    (run_cycles),
    .trigger_count (trigger_count),
    .timeout       (timeout),
    .run_end       (run_end_s)
  );

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
Host-side sequencer that drives the CPU top-level's code-memory write port and core control.
- Accepts a valid/ready stream of 32-bit instruction words and writes them to code memory from word address 0 upward.
- Then holds the core in reset for a fixed interval, releases it, and runs it until trap or timeout.
- Reports the cycle count and the number of decode-trigger pulses for trace alignment.

Parameters:
ADDR_W, 13, code-memory word-address width (depth 2**ADDR_W words)
RESET_HOLD, 4, cycles core_resetn is held low with core_clk_en high before the run starts (min 2)
RUN_TIMEOUT, 1000000, run-cycle limit before a forced stop

Ports:
clk  in  1  system clock; code-memory port clocked by the same clk externally
resetn  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; begins load (or rerun); honoured only in IDLE or DONE
abort  in  1  single-cycle pulse; returns to IDLE from any state
load_len  in  ADDR_W+1  number of words to load, sampled on start; 0 = rerun without loading
s_valid  in  1  host word valid
s_data  in  32  host instruction word
s_ready  out  1  loader accepts word
inst_mem_en  out  1  code-memory write enable
inst_mem_wen  out  4  byte write strobes
inst_mem_addr  out  ADDR_W  word address
inst_mem_data  out  32  write data
core_resetn  out  1  core reset (active-low)
core_clk_en  out  1  core clock enable
trap  in  1  core trap
dec_trigger  in  1  core decode-trigger pulse
busy  out  1  state is LOAD, HOLD or RUN
done  out  1  state is DONE
timeout  out  1  last run ended on RUN_TIMEOUT
run_cycles  out  32  cycles spent in RUN
trigger_count  out  16  dec_trigger pulses seen in RUN; saturates at 16'hFFFF

Behaviour:
- Reset values:
  - State IDLE.
  - All outputs 0, including core_resetn (core held in reset) and core_clk_en.
  - All counters 0.
- Outputs are registered. Memory-port outputs change one cycle after the accepted handshake.
- States: IDLE, LOAD, HOLD, RUN, DONE.
- IDLE:
  - start with load_len != 0: latch len = min(load_len, 2**ADDR_W), clear addr, run_cycles, trigger_count and timeout; go to LOAD.
  - start with load_len == 0: clear the same registers; go to HOLD.
- LOAD:
  - s_ready = 1.
  - Each s_valid && s_ready cycle: next cycle inst_mem_en = 1, inst_mem_wen = 4'hF, inst_mem_addr = addr, inst_mem_data = s_data; then addr increments.
  - Non-handshake cycles: inst_mem_en = 0 and inst_mem_wen = 0.
  - Gaps in s_valid are tolerated; there is no timeout in LOAD.
  - On accepting word len-1: s_ready drops in the following cycle; go to HOLD.
  - addr never exceeds 2**ADDR_W-1. len = 2**ADDR_W writes the full memory with no wrap.
- HOLD:
  - core_resetn = 0, core_clk_en = 1.
  - Stay RESET_HOLD cycles, then go to RUN.
- RUN:
  - core_resetn = 1, core_clk_en = 1.
  - run_cycles increments every cycle.
  - trigger_count increments on dec_trigger, saturating.
  - trap = 1: go to DONE, with run_cycles including that cycle.
  - run_cycles reaching RUN_TIMEOUT: go to DONE, timeout = 1.
  - trap and timeout in the same cycle: trap wins, timeout = 0.
- DONE:
  - core_clk_en = 0 (core frozen for readout), core_resetn = 1.
  - Counters and timeout hold.
  - start behaves as in IDLE.
- abort:
  - From any state, the next state is IDLE, with core_resetn = 0, core_clk_en = 0, s_ready = 0 and inst_mem_en = 0.
  - Counters hold.
  - A write already registered completes in that same cycle.
- abort and start in the same cycle: abort wins; start is ignored.
- start in LOAD, HOLD or RUN is ignored.
- Asynchronous reset mid-operation: immediate return to reset values; a partially loaded memory is left as is.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, LOAD, HOLD, RUN, DONE);
  - the full-word strobe constant 4'hF;
  - the default RUN_TIMEOUT.
- One natural sub-module, run_monitor: owns the run_cycles and trigger_count counters and timeout detection, and is enabled by RUN.
- Everything else lives in the single FSM module.

Test Plan:
- start, load_len = 4, words 0x00000013, 0x00100093, 0x00200113, 0x00100073 with s_valid always high -> four writes at addr 0..3 with wen = 4'hF, then RESET_HOLD cycles of core_resetn = 0, then RUN.
- Same load with s_valid toggling every other cycle -> identical address/data sequence, with inst_mem_en low on gap cycles.
- RUN with trap asserted on the 50th RUN cycle and dec_trigger pulsed 12 times -> done = 1, run_cycles = 50, trigger_count = 12, timeout = 0, core_clk_en = 0.
- RUN_TIMEOUT = 100 and no trap -> done = 1, timeout = 1, run_cycles = 100.
- abort after 2 of 8 words -> IDLE, s_ready = 0, core_resetn = 0; a following start with load_len = 0 -> HOLD then RUN.
- start pulsed during RUN -> ignored; start and abort together in DONE -> IDLE, counters unchanged.
